// File: rtl/gpio_access_ctrl.sv
// gpio_access_ctrl
// Two-requester arbiter and sequencer in front of a GPIO block. Each granted
// transaction runs IDLE -> EXEC -> ACK (three cycles). Shadow copies of the
// GPIO output and direction registers make SET/CLR/TOGGLE single atomic
// read-modify-write operations.

module gpio_access_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_Clk,
  input  logic             i_rst,
  input  logic             i_req0,
  input  logic [2:0]       i_op0,
  input  logic [WIDTH-1:0] i_data0,
  output logic             o_ack0,
  input  logic             i_req1,
  input  logic [2:0]       i_op1,
  input  logic [WIDTH-1:0] i_data1,
  output logic             o_ack1,
  output logic [WIDTH-1:0] o_rdata,
  output logic [WIDTH-1:0] o_DD,
  output logic             o_WEO,
  output logic             o_WER,
  input  logic [WIDTH-1:0] i_DIN,
  output logic             o_busy,
  output logic             o_gnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_WR_OUT  = 3'd0,
    OP_WR_DIR  = 3'd1,
    OP_SET_OUT = 3'd2,
    OP_CLR_OUT = 3'd3,
    OP_TGL_OUT = 3'd4,
    OP_RD_IN   = 3'd5,
    OP_RD_OUT  = 3'd6,
    OP_RD_DIR  = 3'd7
  } op_e;

  // Registered state
  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] out_sh_q, out_sh_d;
  logic [WIDTH-1:0] dir_sh_q, dir_sh_d;
  logic [WIDTH-1:0] dd_q, dd_d;
  logic             weo_q, weo_d;
  logic             wer_q, wer_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // Winner selection and the value it would write
  logic             win_sel;
  op_e              win_op;
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] win_new_out;

  // Pick the winner: a lone request wins; on a tie the requester that was
  // not served last wins, so neither side can starve.
  always_comb begin
    win_sel = 1'b0;
    if (i_req0 && i_req1) begin
      win_sel = ~gnt_q;
    end else if (i_req1) begin
      win_sel = 1'b1;
    end
    win_op   = win_sel ? op_e'(i_op1) : op_e'(i_op0);
    win_data = win_sel ? i_data1 : i_data0;
  end

  // New output-register value for the winner, computed from the shadow so
  // the read-modify-write never has to read the GPIO block itself.
  always_comb begin
    win_new_out = out_sh_q;
    case (win_op)
      OP_WR_OUT:  win_new_out = win_data;
      OP_SET_OUT: win_new_out = out_sh_q | win_data;
      OP_CLR_OUT: win_new_out = out_sh_q & ~win_data;
      OP_TGL_OUT: win_new_out = out_sh_q ^ win_data;
      default:    win_new_out = out_sh_q;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/EXEC/ACK sequence.
  // dd_q doubles as the latched write value: the shadow update at the end
  // of EXEC takes exactly what was driven to the GPIO block.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    out_sh_d = out_sh_q;
    dir_sh_d = dir_sh_q;
    dd_d     = dd_q;
    weo_d    = 1'b0;
    wer_d    = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req0 || i_req1) begin
          gnt_d   = win_sel;
          op_d    = win_op;
          state_d = ST_EXEC;
          case (win_op)
            OP_WR_OUT, OP_SET_OUT, OP_CLR_OUT, OP_TGL_OUT: begin
              weo_d = 1'b1;
              dd_d  = win_new_out;
            end
            OP_WR_DIR: begin
              wer_d = 1'b1;
              dd_d  = win_data;
            end
            default: begin
              // reads leave the GPIO data bus untouched
            end
          endcase
        end
      end

      ST_EXEC: begin
        state_d = ST_ACK;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        rdata_d = '0;
        case (op_q)
          OP_WR_OUT, OP_SET_OUT, OP_CLR_OUT, OP_TGL_OUT: out_sh_d = dd_q;
          OP_WR_DIR: dir_sh_d = dd_q;
          OP_RD_IN:  rdata_d  = i_DIN;
          OP_RD_OUT: rdata_d  = out_sh_q;
          OP_RD_DIR: rdata_d  = dir_sh_q;
          default:   rdata_d  = '0;
        endcase
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset drops any transaction in flight without an ack.
  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b1;
      op_q     <= OP_WR_OUT;
      out_sh_q <= '0;
      dir_sh_q <= '0;
      dd_q     <= '0;
      weo_q    <= 1'b0;
      wer_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      out_sh_q <= out_sh_d;
      dir_sh_q <= dir_sh_d;
      dd_q     <= dd_d;
      weo_q    <= weo_d;
      wer_q    <= wer_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_ack0  = ack0_q;
  assign o_ack1  = ack1_q;
  assign o_rdata = rdata_q;
  assign o_DD    = dd_q;
  assign o_WEO   = weo_q;
  assign o_WER   = wer_q;
  assign o_gnt   = gnt_q;
  assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpio_access_ctrl.sv
// Directed bench for gpio_access_ctrl with hand-computed expected values.

module tb_gpio_access_ctrl;

  localparam int WIDTH = 32;

  logic             i_Clk;
  logic             i_rst;
  logic             i_req0;
  logic [2:0]       i_op0;
  logic [WIDTH-1:0] i_data0;
  logic             o_ack0;
  logic             i_req1;
  logic [2:0]       i_op1;
  logic [WIDTH-1:0] i_data1;
  logic             o_ack1;
  logic [WIDTH-1:0] o_rdata;
  logic [WIDTH-1:0] o_DD;
  logic             o_WEO;
  logic             o_WER;
  logic [WIDTH-1:0] i_DIN;
  logic             o_busy;
  logic             o_gnt;

  int total_cnt = 0;
  int bad_cnt   = 0;

  gpio_access_ctrl #(.WIDTH(WIDTH)) dut (
    .i_Clk   (i_Clk),
    .i_rst   (i_rst),
    .i_req0  (i_req0),
    .i_op0   (i_op0),
    .i_data0 (i_data0),
    .o_ack0  (o_ack0),
    .i_req1  (i_req1),
    .i_op1   (i_op1),
    .i_data1 (i_data1),
    .o_ack1  (o_ack1),
    .o_rdata (o_rdata),
    .o_DD    (o_DD),
    .o_WEO   (o_WEO),
    .o_WER   (o_WER),
    .i_DIN   (i_DIN),
    .o_busy  (o_busy),
    .o_gnt   (o_gnt)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction from IDLE: EXEC checks in cycle 1, ACK checks in
  // cycle 2, back to IDLE in cycle 3.
  task automatic txn(input int who, input logic [2:0] op, input logic [31:0] d,
                     input logic [31:0] exp_dd, input logic exp_weo,
                     input logic exp_wer, input logic [31:0] exp_rd);
    if (who == 0) begin
      i_req0 = 1'b1; i_op0 = op; i_data0 = d;
    end else begin
      i_req1 = 1'b1; i_op1 = op; i_data1 = d;
    end
    tick();
    chk("exec_busy", {31'd0, o_busy}, 32'd1);
    chk("exec_weo", {31'd0, o_WEO}, {31'd0, exp_weo});
    chk("exec_wer", {31'd0, o_WER}, {31'd0, exp_wer});
    if (exp_weo || exp_wer) chk("exec_dd", o_DD, exp_dd);
    chk("exec_noack", {30'd0, o_ack1, o_ack0}, 32'd0);
    tick();
    chk("ack_acks", {30'd0, o_ack1, o_ack0}, (who == 0) ? 32'd1 : 32'd2);
    chk("ack_strobes", {30'd0, o_WER, o_WEO}, 32'd0);
    chk("ack_rdata", o_rdata, exp_rd);
    chk("ack_gnt", {31'd0, o_gnt}, who[31:0]);
    if (who == 0) i_req0 = 1'b0; else i_req1 = 1'b0;
    tick();
    chk("idle_busy", {31'd0, o_busy}, 32'd0);
    $display("txn who=%0d op=%0d data=%h dd=%h rdata_exp=%h", who, op, d, o_DD, exp_rd);
  endtask

  initial begin
    i_rst = 1'b1;
    i_req0 = 1'b0; i_op0 = 3'd0; i_data0 = '0;
    i_req1 = 1'b0; i_op1 = 3'd0; i_data1 = '0;
    i_DIN = '0;
    tick();
    tick();
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_strobes", {30'd0, o_WER, o_WEO}, 32'd0);
    chk("rst_acks", {30'd0, o_ack1, o_ack0}, 32'd0);
    chk("rst_dd", o_DD, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_gnt", {31'd0, o_gnt}, 32'd1);
    i_rst = 1'b0;
    tick();

    // Basic write and readback
    txn(0, 3'd0, 32'hA5A5_0000, 32'hA5A5_0000, 1'b1, 1'b0, 32'h0);
    chk("dd_hold_idle", o_DD, 32'hA5A5_0000);
    txn(0, 3'd6, 32'h0, 32'h0, 1'b0, 1'b0, 32'hA5A5_0000);
    chk("dd_hold_read", o_DD, 32'hA5A5_0000);

    // Read-modify-write ops
    txn(1, 3'd0, 32'hFF00_00F0, 32'hFF00_00F0, 1'b1, 1'b0, 32'h0);
    txn(1, 3'd2, 32'h0000_000F, 32'hFF00_00FF, 1'b1, 1'b0, 32'h0);
    txn(0, 3'd3, 32'hFF00_0000, 32'h0000_00FF, 1'b1, 1'b0, 32'h0);
    txn(1, 3'd4, 32'h0000_0101, 32'h0000_01FE, 1'b1, 1'b0, 32'h0);
    txn(0, 3'd6, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_01FE);

    // Direction register and input sampling
    txn(1, 3'd1, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0, 1'b1, 32'h0);
    txn(0, 3'd7, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_0000);
    i_DIN = 32'h1234_5678;
    txn(1, 3'd5, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1234_5678);
    chk("dd_hold_dir", o_DD, 32'hFFFF_0000);
    txn(0, 3'd6, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_01FE);

    // Arbitration: tie after reset goes to requester 0, then alternates
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("arb_rst_gnt", {31'd0, o_gnt}, 32'd1);
    i_req0 = 1'b1; i_op0 = 3'd0; i_data0 = 32'h0000_0011;
    i_req1 = 1'b1; i_op1 = 3'd1; i_data1 = 32'h0000_0022;
    tick();
    chk("arb1_gnt", {31'd0, o_gnt}, 32'd0);
    chk("arb1_weo", {31'd0, o_WEO}, 32'd1);
    chk("arb1_wer", {31'd0, o_WER}, 32'd0);
    chk("arb1_dd", o_DD, 32'h0000_0011);
    tick();
    chk("arb1_acks", {30'd0, o_ack1, o_ack0}, 32'd1);
    i_req0 = 1'b0;
    tick();
    chk("arb_idle_busy", {31'd0, o_busy}, 32'd0);
    tick();
    chk("arb2_gnt", {31'd0, o_gnt}, 32'd1);
    chk("arb2_wer", {31'd0, o_WER}, 32'd1);
    chk("arb2_dd", o_DD, 32'h0000_0022);
    tick();
    chk("arb2_acks", {30'd0, o_ack1, o_ack0}, 32'd2);
    i_req0 = 1'b1; i_op0 = 3'd6; i_data0 = '0;
    tick();
    tick();
    chk("arb3_gnt", {31'd0, o_gnt}, 32'd0);
    chk("arb3_strobes", {30'd0, o_WER, o_WEO}, 32'd0);
    tick();
    chk("arb3_acks", {30'd0, o_ack1, o_ack0}, 32'd1);
    chk("arb3_rdata", o_rdata, 32'h0000_0011);
    i_req0 = 1'b0;
    tick();
    tick();
    chk("arb4_gnt", {31'd0, o_gnt}, 32'd1);
    chk("arb4_wer", {31'd0, o_WER}, 32'd1);
    tick();
    chk("arb4_acks", {30'd0, o_ack1, o_ack0}, 32'd2);
    i_req1 = 1'b0;
    tick();

    // Reset in the middle of a SET drops it
    txn(0, 3'd0, 32'h0000_00F0, 32'h0000_00F0, 1'b1, 1'b0, 32'h0);
    i_req0 = 1'b1; i_op0 = 3'd2; i_data0 = 32'h0000_000F;
    tick();
    chk("mid_weo", {31'd0, o_WEO}, 32'd1);
    chk("mid_dd", o_DD, 32'h0000_00FF);
    i_rst = 1'b1; i_req0 = 1'b0;
    tick();
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("mid_rst_strobes", {30'd0, o_WER, o_WEO}, 32'd0);
    chk("mid_rst_acks", {30'd0, o_ack1, o_ack0}, 32'd0);
    chk("mid_rst_dd", o_DD, 32'd0);
    chk("mid_rst_gnt", {31'd0, o_gnt}, 32'd1);
    i_rst = 1'b0;
    tick();
    chk("mid_noack", {30'd0, o_ack1, o_ack0}, 32'd0);
    txn(0, 3'd6, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    txn(1, 3'd7, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Requester 1 holds req through its ack: a second transaction follows
    i_DIN = 32'h0000_CAFE;
    i_req1 = 1'b1; i_op1 = 3'd5; i_data1 = '0;
    tick();
    chk("hold_exec1", {31'd0, o_busy}, 32'd1);
    tick();
    chk("hold_ack1", {30'd0, o_ack1, o_ack0}, 32'd2);
    chk("hold_rd1", o_rdata, 32'h0000_CAFE);
    tick();
    chk("hold_idle", {31'd0, o_busy}, 32'd0);
    chk("hold_idle_acks", {30'd0, o_ack1, o_ack0}, 32'd0);
    chk("hold_rd_keep", o_rdata, 32'h0000_CAFE);
    tick();
    chk("hold_exec2", {31'd0, o_busy}, 32'd1);
    i_DIN = 32'h0000_BEEF;
    tick();
    chk("hold_ack2", {30'd0, o_ack1, o_ack0}, 32'd2);
    chk("hold_rd2", o_rdata, 32'h0000_BEEF);
    i_req1 = 1'b0;
    tick();
    chk("hold_end_busy", {31'd0, o_busy}, 32'd0);
    tick();
    chk("hold_no_third", {31'd0, o_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
